// File: rtl/iigs_hps_io_pkg.sv
// ----------------------------------------------------------------------------
// iigs_hps_io_pkg
//   Shared constants for the IIgs HPS I/O bridge: command opcodes carried in
//   the low byte of the first word of a frame, the sector buffer size, and
//   the bit positions of the ps2_key fields. Also holds a small helper that
//   picks the lowest-numbered disk with a pending request.
// ----------------------------------------------------------------------------
package iigs_hps_io_pkg;

    localparam logic [7:0] CMD_BUT_SW     = 8'h01;
    localparam logic [7:0] CMD_PS2        = 8'h05;
    localparam logic [7:0] CMD_SD_STAT    = 8'h16;
    localparam logic [7:0] CMD_SD_RD      = 8'h17;
    localparam logic [7:0] CMD_SD_WR      = 8'h18;
    localparam logic [7:0] CMD_IMG_MOUNT  = 8'h1C;
    localparam logic [7:0] CMD_SET_STATUS = 8'h1E;
    localparam logic [7:0] CMD_GET_MASK   = 8'h1F;

    localparam int SECTOR_BYTES = 512;

    // ps2_key layout: [10] toggle, [9] pressed, [8] extended, [7:0] scancode
    localparam int PS2_TOGGLE   = 10;
    localparam int PS2_PRESSED  = 9;
    localparam int PS2_EXTENDED = 8;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/iigs_hps_io_sdxfer.sv
// ----------------------------------------------------------------------------
// iigs_hps_io_sdxfer
//   Sector-buffer transfer engine for SECTOR_RD (HPS->core) and SECTOR_WR
//   (core->HPS). Owns the byte counter, the buffer address, the per-disk ack
//   and the buffer write strobe. A transfer starts at the command strobe and
//   lasts until io_enable drops; bytes past the end of the sector are
//   ignored rather than wrapped.
// Ports
//   clk_sys, reset   clock, asynchronous active-high reset
//   io_enable        frame enable; low clears the transfer
//   start, start_wr  command strobe of a transfer command / it is a write
//   byte_stb         data strobe of the current frame
//   byte_in          low byte of the HPS word (read transfers)
//   drive            disk selected by the last GET_SDSTAT
//   sd_ack           per-disk transfer-active flag
//   sd_buff_addr     buffer byte address
//   sd_buff_dout     byte written into the core buffer
//   sd_buff_wr       one-cycle write pulse
//   byte_ok          current strobe falls inside the sector
// ----------------------------------------------------------------------------
module iigs_hps_io_sdxfer
    import iigs_hps_io_pkg::*;
#(
    parameter int VDNUM = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             io_enable,
    input  logic             start,
    input  logic             start_wr,
    input  logic             byte_stb,
    input  logic [7:0]       byte_in,
    input  logic [1:0]       drive,
    output logic [VDNUM-1:0] sd_ack,
    output logic [8:0]       sd_buff_addr,
    output logic [7:0]       sd_buff_dout,
    output logic             sd_buff_wr,
    output logic             byte_ok
);

    logic       busy;
    logic       wr_mode;
    logic [9:0] cnt;

    assign byte_ok = busy && (cnt < 10'(SECTOR_BYTES));

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            wr_mode      <= 1'b0;
            cnt          <= '0;
            sd_ack       <= '0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
        end else begin
            sd_buff_wr <= 1'b0;
            if (!io_enable) begin
                busy    <= 1'b0;
                wr_mode <= 1'b0;
                cnt     <= '0;
                sd_ack  <= '0;
            end else if (start) begin
                busy         <= 1'b1;
                wr_mode      <= start_wr;
                cnt          <= '0;
                sd_buff_addr <= '0;
                for (int i = 0; i < VDNUM; i++) sd_ack[i] <= (drive == 2'(i));
            end else if (byte_stb && byte_ok) begin
                cnt <= cnt + 10'd1;
                if (wr_mode) begin
                    // Pre-advance so the core's 1-cycle buffer read is ready
                    // for the next strobe; hold at the last byte, no wrap.
                    if (cnt != 10'(SECTOR_BYTES - 1)) sd_buff_addr <= sd_buff_addr + 9'd1;
                end else begin
                    sd_buff_addr <= cnt[8:0];
                    sd_buff_dout <= byte_in;
                    sd_buff_wr   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iigs_hps_io.sv
// ----------------------------------------------------------------------------
// iigs_hps_io
//   HPS I/O bridge for the IIgs core. Decodes framed 16-bit command transfers
//   (first strobe = opcode, later strobes = data words) and exposes buttons,
//   scandoubler flag, OSD status, PS/2 key events, image-mount info and a
//   byte-wide sector-buffer handshake for VDNUM virtual disks.
// Configuration
//   HPS_IO_PS2_EN  defined: command 0x05 drives ps2_key.
//                  undefined: ps2_key tied 0, 0x05 handled as unknown.
// Ports
//   clk_sys, reset        clock, asynchronous active-high reset
//   io_enable/io_strobe   frame enable / one-cycle word strobe
//   io_din / io_dout      HPS->core word / core->HPS word (cycle after strobe)
//   buttons, forced_scandoubler, status, status_menumask   OSD interface
//   ps2_key               keyboard event
//   sd_lba, sd_rd, sd_wr  per-disk requests from the core
//   sd_ack, sd_buff_*     sector-buffer handshake
//   img_mounted, img_readonly, img_size   mount notification
// ----------------------------------------------------------------------------
module iigs_hps_io
    import iigs_hps_io_pkg::*;
#(
    parameter int VDNUM = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             io_enable,
    input  logic             io_strobe,
    input  logic [15:0]      io_din,
    output logic [15:0]      io_dout,
    output logic [1:0]       buttons,
    output logic             forced_scandoubler,
    output logic [31:0]      status,
    input  logic [15:0]      status_menumask,
    output logic [10:0]      ps2_key,
    input  logic [31:0]      sd_lba [VDNUM],
    input  logic [VDNUM-1:0] sd_rd,
    input  logic [VDNUM-1:0] sd_wr,
    output logic [VDNUM-1:0] sd_ack,
    output logic [8:0]       sd_buff_addr,
    output logic [7:0]       sd_buff_dout,
    input  logic [7:0]       sd_buff_din [VDNUM],
    output logic             sd_buff_wr,
    output logic [VDNUM-1:0] img_mounted,
    output logic             img_readonly,
    output logic [63:0]      img_size
);

    logic        en_d;
    logic        have_cmd;
    logic [7:0]  cmd;
    logic [2:0]  word_cnt;
    logic        cmd_stb;
    logic        data_stb;
    logic        frame_end;
    logic [3:0]  req4;
    logic [1:0]  active;
    logic        req_valid;
    logic [15:0] status_lo;
    logic [1:0]  mnt_drive;
    logic        mnt_ro;
    logic [63:0] mnt_size;
    logic [7:0]  din_sel;
    logic [31:0] lba_sel;
    logic        xfer_start;
    logic        byte_ok;

    assign cmd_stb    = io_strobe & io_enable & ~have_cmd;
    assign data_stb   = io_strobe & io_enable & have_cmd;
    assign frame_end  = en_d & ~io_enable;
    assign req4       = 4'(sd_rd | sd_wr);
    assign xfer_start = cmd_stb && (io_din[7:0] == CMD_SD_RD || io_din[7:0] == CMD_SD_WR);

    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        din_sel = '0;
        lba_sel = '0;
        for (int i = 0; i < VDNUM; i++) begin
            if (active == 2'(i)) begin
                din_sel = sd_buff_din[i];
                lba_sel = sd_lba[i];
            end
        end
    end

    // Frame tracking. word_cnt saturates so long sector frames never alias
    // back onto the low word numbers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            en_d     <= 1'b0;
            have_cmd <= 1'b0;
            cmd      <= '0;
            word_cnt <= '0;
        end else begin
            en_d <= io_enable;
            if (!io_enable) begin
                have_cmd <= 1'b0;
                cmd      <= '0;
                word_cnt <= '0;
            end else if (cmd_stb) begin
                have_cmd <= 1'b1;
                cmd      <= io_din[7:0];
                word_cnt <= '0;
            end else if (data_stb && word_cnt != 3'd7) begin
                word_cnt <= word_cnt + 3'd1;
            end
        end
    end

    // Command decode and the registers it updates.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            io_dout            <= '0;
            buttons            <= '0;
            forced_scandoubler <= 1'b0;
            status             <= '0;
            status_lo          <= '0;
            active             <= '0;
            req_valid          <= 1'b0;
            mnt_drive          <= '0;
            mnt_ro             <= 1'b0;
            mnt_size           <= '0;
            img_mounted        <= '0;
            img_readonly       <= 1'b0;
            img_size           <= '0;
        end else begin
            img_mounted <= '0;
            if (!io_enable) begin
                io_dout <= '0;
            end else if (cmd_stb) begin
                io_dout <= '0;
                if (io_din[7:0] == CMD_SD_STAT) begin
                    active    <= lowest_set(req4);
                    req_valid <= |req4;
                end
                if (io_din[7:0] == CMD_IMG_MOUNT) begin
                    mnt_drive <= '0;
                    mnt_ro    <= 1'b0;
                    mnt_size  <= '0;
                end
            end else if (data_stb) begin
                io_dout <= '0;
                case (cmd)
                    CMD_BUT_SW: if (word_cnt == 3'd0) begin
                        buttons            <= io_din[1:0];
                        forced_scandoubler <= io_din[4];
                    end
                    CMD_SET_STATUS: begin
                        // Low half is staged so status changes in one step.
                        if (word_cnt == 3'd0) status_lo <= io_din;
                        if (word_cnt == 3'd1) status    <= {io_din, status_lo};
                    end
                    CMD_GET_MASK: if (word_cnt == 3'd0) io_dout <= status_menumask;
                    CMD_SD_STAT: begin
                        if (word_cnt == 3'd0) io_dout <= {8'(sd_wr), 8'(sd_rd)};
                        if (word_cnt == 3'd1) io_dout <= req_valid ? lba_sel[15:0]  : 16'h0;
                        if (word_cnt == 3'd2) io_dout <= req_valid ? lba_sel[31:16] : 16'h0;
                    end
                    CMD_SD_WR: io_dout <= byte_ok ? {8'h00, din_sel} : io_dout;
                    CMD_IMG_MOUNT: begin
                        case (word_cnt)
                            3'd0: begin
                                mnt_drive <= io_din[1:0];
                                mnt_ro    <= io_din[7];
                            end
                            3'd1:    mnt_size[15:0]  <= io_din;
                            3'd2:    mnt_size[31:16] <= io_din;
                            3'd3:    mnt_size[47:32] <= io_din;
                            3'd4:    mnt_size[63:48] <= io_din;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            if (frame_end && cmd == CMD_IMG_MOUNT && int'(mnt_drive) < VDNUM) begin
                for (int i = 0; i < VDNUM; i++) img_mounted[i] <= (mnt_drive == 2'(i));
                img_size     <= mnt_size;
                img_readonly <= mnt_ro;
            end
        end
    end

`ifdef HPS_IO_PS2_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ps2_key <= '0;
        end else if (data_stb && cmd == CMD_PS2 && word_cnt == 3'd0) begin
            ps2_key <= {~ps2_key[PS2_TOGGLE], io_din[PS2_PRESSED], io_din[PS2_EXTENDED], io_din[7:0]};
        end
    end
`else
    assign ps2_key = '0;
`endif

    iigs_hps_io_sdxfer #(
        .VDNUM(VDNUM)
    ) u_sdxfer (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .io_enable    (io_enable),
        .start        (xfer_start),
        .start_wr     (io_din[7:0] == CMD_SD_WR),
        .byte_stb     (data_stb),
        .byte_in      (io_din[7:0]),
        .drive        (active),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .byte_ok      (byte_ok)
    );

endmodule

// File: tb/tb_iigs_hps_io.sv
// ----------------------------------------------------------------------------
// tb_iigs_hps_io
//   Self-checking bench for iigs_hps_io. Drives framed HPS transfers with
//   randomized payloads and compares outputs against expectations derived
//   from the command rules (a first-request search, word-by-word response
//   table, and a byte array standing in for the core's sector buffers).
// ----------------------------------------------------------------------------
module tb_iigs_hps_io;

    localparam int VDNUM = 2;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             io_enable;
    logic             io_strobe;
    logic [15:0]      io_din;
    logic [15:0]      io_dout;
    logic [1:0]       buttons;
    logic             forced_scandoubler;
    logic [31:0]      status;
    logic [15:0]      status_menumask;
    logic [10:0]      ps2_key;
    logic [31:0]      sd_lba [VDNUM];
    logic [VDNUM-1:0] sd_rd;
    logic [VDNUM-1:0] sd_wr;
    logic [VDNUM-1:0] sd_ack;
    logic [8:0]       sd_buff_addr;
    logic [7:0]       sd_buff_dout;
    logic [7:0]       sd_buff_din [VDNUM];
    logic             sd_buff_wr;
    logic [VDNUM-1:0] img_mounted;
    logic             img_readonly;
    logic [63:0]      img_size;

    // Core-side sector buffers with one cycle of read latency.
    logic [7:0] disk_mem [VDNUM][512];

    // Reference state
    int          exp_active = 0;
    logic [31:0] exp_status = '0;
    logic [10:0] exp_ps2    = '0;

    int n_vec = 0;
    int n_err = 0;

    iigs_hps_io #(.VDNUM(VDNUM)) dut (
        .clk_sys            (clk_sys),
        .reset              (reset),
        .io_enable          (io_enable),
        .io_strobe          (io_strobe),
        .io_din             (io_din),
        .io_dout            (io_dout),
        .buttons            (buttons),
        .forced_scandoubler (forced_scandoubler),
        .status             (status),
        .status_menumask    (status_menumask),
        .ps2_key            (ps2_key),
        .sd_lba             (sd_lba),
        .sd_rd              (sd_rd),
        .sd_wr              (sd_wr),
        .sd_ack             (sd_ack),
        .sd_buff_addr       (sd_buff_addr),
        .sd_buff_dout       (sd_buff_dout),
        .sd_buff_din        (sd_buff_din),
        .sd_buff_wr         (sd_buff_wr),
        .img_mounted        (img_mounted),
        .img_readonly       (img_readonly),
        .img_size           (img_size)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        for (int i = 0; i < VDNUM; i++) sd_buff_din[i] <= disk_mem[i][sd_buff_addr];
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the falling
    // edge after the rising edge that registered the strobe.
    task automatic strobe(input logic [15:0] w);
        @(negedge clk_sys);
        io_din    = w;
        io_strobe = 1'b1;
        @(negedge clk_sys);
        io_strobe = 1'b0;
    endtask

    task automatic open_frame(input logic [7:0] c);
        @(negedge clk_sys);
        io_enable = 1'b1;
        strobe({8'($urandom), c});
    endtask

    task automatic close_frame();
        @(negedge clk_sys);
        io_enable = 1'b0;
        @(negedge clk_sys);
    endtask

    function automatic int first_request(input logic [VDNUM-1:0] rd, input logic [VDNUM-1:0] wr);
        for (int i = 0; i < VDNUM; i++) begin
            if (rd[i] || wr[i]) return i;
        end
        return -1;
    endfunction

    task automatic sdstat_frame(input string tag);
        int          r;
        logic [31:0] lba;
        r   = first_request(sd_rd, sd_wr);
        lba = (r < 0) ? 32'h0 : sd_lba[r];
        open_frame(8'h16);
        strobe(16'($urandom));
        check({tag, "_w0"}, io_dout, (int'(sd_wr) * 256) + int'(sd_rd));
        strobe(16'($urandom));
        check({tag, "_w1"}, io_dout, lba % 65536);
        strobe(16'($urandom));
        check({tag, "_w2"}, io_dout, lba / 65536);
        close_frame();
        exp_active = (r < 0) ? 0 : r;
    endtask

    initial begin : main
        logic [15:0]      w0;
        logic [15:0]      w1;
        logic [63:0]      sz;
        logic [VDNUM-1:0] exp_ack;
        logic [VDNUM-1:0] exp_mnt;
        logic [63:0]      exp_size;
        logic             exp_ro;
        int               drv;
        logic [7:0]       unk [4];

        reset           = 1'b1;
        io_enable       = 1'b0;
        io_strobe       = 1'b0;
        io_din          = '0;
        sd_rd           = '0;
        sd_wr           = '0;
        status_menumask = '0;
        exp_size        = '0;
        exp_ro          = 1'b0;
        for (int d = 0; d < VDNUM; d++) begin
            sd_lba[d] = '0;
            for (int i = 0; i < 512; i++)
                disk_mem[d][i] = (d == 1) ? (8'(i) ^ 8'h5A) : 8'($urandom);
        end

        repeat (3) @(negedge clk_sys);
        check("rst_io_dout", io_dout, 0);
        check("rst_buttons", buttons, 0);
        check("rst_fsd", forced_scandoubler, 0);
        check("rst_status", status, 0);
        check("rst_ps2", ps2_key, 0);
        check("rst_ack", sd_ack, 0);
        check("rst_addr", sd_buff_addr, 0);
        check("rst_bwr", sd_buff_wr, 0);
        check("rst_mounted", img_mounted, 0);
        check("rst_size", img_size, 0);
        check("rst_ro", img_readonly, 0);
        reset = 1'b0;

        // SET_STATUS: no change after the low word, whole word after the high.
        for (int k = 0; k < 4; k++) begin
            w0 = (k == 0) ? 16'h0001 : 16'($urandom);
            w1 = (k == 0) ? 16'h8000 : 16'($urandom);
            open_frame(8'h1E);
            strobe(w0);
            check("status_w0", status, exp_status);
            strobe(w1);
            exp_status = (32'(w1) << 16) | 32'(w0);
            check("status_w1", status, exp_status);
            close_frame();
        end

        // BUT_SW
        for (int k = 0; k < 4; k++) begin
            w0 = 16'($urandom);
            open_frame(8'h01);
            strobe(w0);
            close_frame();
            check("buttons", buttons, w0 % 4);
            check("fsd", forced_scandoubler, (w0 >> 4) % 2);
        end

        // GET_MASK, and io_dout returning to 0 once the frame ends
        for (int k = 0; k < 3; k++) begin
            status_menumask = 16'($urandom);
            open_frame(8'h1F);
            strobe(16'($urandom));
            check("get_mask", io_dout, status_menumask);
            close_frame();
            check("dout_idle", io_dout, 0);
        end

        // GET_SDSTAT: fixed case, then random request patterns
        sd_rd = 2'b10; sd_wr = 2'b00;
        sd_lba[0] = $urandom; sd_lba[1] = 32'h0001_2345;
        sdstat_frame("sdstat_fixed");
        sd_rd = '0; sd_wr = '0;
        sdstat_frame("sdstat_none");
        for (int k = 0; k < 4; k++) begin
            sd_rd = VDNUM'($urandom); sd_wr = VDNUM'($urandom);
            sd_lba[0] = $urandom; sd_lba[1] = $urandom;
            sdstat_frame("sdstat_rand");
        end

        // SECTOR_RD: full sector, then one byte too many
        sd_rd = VDNUM'($urandom_range(1, (1 << VDNUM) - 1)); sd_wr = '0;
        sdstat_frame("sdstat_rd");
        sd_rd = '0;
        exp_ack = '0; exp_ack[exp_active] = 1'b1;
        open_frame(8'h17);
        check("rd_ack", sd_ack, exp_ack);
        for (int i = 0; i < 512; i++) begin
            strobe({8'($urandom), 8'(i)});
            check("rd_bwr", sd_buff_wr, 1);
            check("rd_addr", sd_buff_addr, i);
            check("rd_data", sd_buff_dout, i % 256);
            if (i == 0) begin
                @(negedge clk_sys);
                check("rd_bwr_pulse", sd_buff_wr, 0);
            end
        end
        strobe(16'h00AA);
        check("rd_513_bwr", sd_buff_wr, 0);
        check("rd_513_addr", sd_buff_addr, 511);
        check("rd_ack_hold", sd_ack, exp_ack);
        close_frame();
        check("rd_ack_drop", sd_ack, 0);

        // SECTOR_WR from disk 1 whose buffer holds i ^ 0x5A
        sd_wr = 2'b10; sd_rd = '0;
        sdstat_frame("sdstat_wr");
        sd_wr = '0;
        open_frame(8'h18);
        check("wr_ack", sd_ack, 2'b10);
        check("wr_addr0", sd_buff_addr, 0);
        for (int i = 0; i < 512; i++) begin
            strobe(16'($urandom));
            check("wr_dout", io_dout, (i % 256) ^ 8'h5A);
        end
        close_frame();
        check("wr_ack_drop", sd_ack, 0);

        // Reset in the middle of a read transfer
        sd_rd = 2'b01;
        sdstat_frame("sdstat_mid");
        sd_rd = '0;
        open_frame(8'h17);
        for (int i = 0; i < 100; i++) strobe(16'(i));
        check("mid_addr", sd_buff_addr, 99);
        #2;
        reset     = 1'b1;
        io_enable = 1'b0;
        @(negedge clk_sys);
        check("mid_rst_ack", sd_ack, 0);
        check("mid_rst_bwr", sd_buff_wr, 0);
        check("mid_rst_addr", sd_buff_addr, 0);
        check("mid_rst_status", status, 0);
        reset      = 1'b0;
        exp_status = '0;
        exp_ps2    = '0;
        exp_active = 0;

        // IMG_MOUNT: fixed case, then random drives (some out of range)
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                w0 = 16'h0081;
                sz = 64'h0000_0000_0200_0000;
            end else begin
                w0 = {8'($urandom), 1'($urandom), 5'($urandom), 2'($urandom)};
                sz = {32'($urandom), 32'($urandom)};
            end
            drv = int'(w0 % 4);
            exp_mnt = '0;
            if (drv < VDNUM) begin
                exp_mnt[drv] = 1'b1;
                exp_size     = sz;
                exp_ro       = w0[7];
            end
            open_frame(8'h1C);
            strobe(w0);
            strobe(sz[15:0]);
            strobe(sz[31:16]);
            strobe(sz[47:32]);
            strobe(sz[63:48]);
            check("mnt_idle", img_mounted, 0);
            close_frame();
            check("mnt_pulse", img_mounted, exp_mnt);
            check("mnt_size", img_size, exp_size);
            check("mnt_ro", img_readonly, exp_ro);
            @(negedge clk_sys);
            check("mnt_pulse_end", img_mounted, 0);
        end

        // Unknown commands return 0 and change nothing
        unk = '{8'h00, 8'h02, 8'h7F, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            open_frame(unk[k]);
            strobe(16'($urandom));
            check("unk_dout", io_dout, 0);
            strobe(16'($urandom));
            close_frame();
            check("unk_status", status, exp_status);
        end

        // PS/2 key events
        for (int k = 0; k < 3; k++) begin
            w0 = 16'($urandom);
            open_frame(8'h05);
            strobe(w0);
            check("ps2_dout", io_dout, 0);
            close_frame();
`ifdef HPS_IO_PS2_EN
            exp_ps2 = {~exp_ps2[10], w0[9:0]};
`endif
            check("ps2_key", ps2_key, exp_ps2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
